// File: rtl/imem_arbiter_pkg.sv
// Shared types for the imem arbiter / boot sequencer.
// Datapath width and the boot/run state encoding.
package imem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_DRAIN,
    ST_RUN
  } imem_arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Loader write-request channel into the imem arbiter.
// Valid/ready handshake carrying one halfword per transfer.
interface imem_arbiter_if;
  import imem_arbiter_pkg::*;

  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_addr;
  logic [15:0]     ld_data;
  logic            ld_last;

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/imem_arbiter.sv
// Boot sequencer and fetch/loader arbiter for the imem write port.
// Fetch has priority; a loader waiting too long is force-granted.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int              MEM_HWORDS   = 8192,
  parameter logic [XLEN-1:0] BOOT_PC      = 32'h8000_0000,
  parameter int              STARVE_LIMIT = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  imem_arbiter_if.slave                 ld,
  input  logic [XLEN-1:0]               fetch_pc_i,
  input  logic                          fetch_stall_i,
  output logic                          mem_we_o,
  output logic [$clog2(MEM_HWORDS)-1:0] mem_waddr_o,
  output logic [15:0]                   mem_wdata_o,
  output logic                          fetch_hold_o,
  output logic                          fetch_flush_o,
  output logic [XLEN-1:0]               fetch_redirect_pc_o,
  output logic                          boot_done_o
);

  localparam int AW = $clog2(MEM_HWORDS);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  imem_arb_state_e r_state;
  imem_arb_state_e w_state_nxt;

  logic            r_first;
  logic [CW-1:0]   r_starve;
  logic [CW-1:0]   w_starve_nxt;
  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [15:0]     r_wdata;
  logic            r_hit;
  logic [XLEN-1:0] r_redir;

  logic            w_ready;
  logic            w_hs;
  logic            w_hit;
  logic [AW-1:0]   w_widx;
  logic [AW-1:0]   w_pidx;
  logic [AW-1:0]   w_pidx2;
  logic            w_unused;

  // Upper address bits wrap silently; bit 0 is a byte offset.
  assign w_widx   = ld.ld_addr[AW:1];
  assign w_pidx   = fetch_pc_i[AW:1];
  assign w_pidx2  = w_pidx + AW'(1);
  assign w_unused = ^{ld.ld_addr[XLEN-1:AW+1], ld.ld_addr[0],
                      fetch_pc_i[XLEN-1:AW+1], fetch_pc_i[0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_starve_nxt = '0;
    unique case (r_state)
      ST_BOOT: begin
        w_ready = 1'b1;
        if (ld.ld_valid && ld.ld_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_ready = !r_first && (fetch_stall_i || (r_starve == LIM));
        if (ld.ld_valid && !w_ready)
          w_starve_nxt = (r_starve == LIM) ? r_starve : r_starve + CW'(1);
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign ld.ld_ready = w_ready & rstn_i;
  assign w_hs        = ld.ld_valid & w_ready;
  assign w_hit       = (r_state == ST_RUN) & w_hs &
                       ((w_widx == w_pidx) | (w_widx == w_pidx2));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_BOOT;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_first  <= 1'b0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_hit    <= 1'b0;
      r_redir  <= BOOT_PC;
    end else begin
      r_first  <= (r_state == ST_DRAIN);
      r_starve <= w_starve_nxt;
      r_we     <= w_hs;
      if (w_hs) begin
        r_waddr <= w_widx;
        r_wdata <= ld.ld_data;
      end
      r_hit <= w_hit;
      if (r_state == ST_DRAIN) r_redir <= BOOT_PC;
      else if (w_hit)          r_redir <= fetch_pc_i;
    end
  end

  assign mem_we_o            = r_we;
  assign mem_waddr_o         = r_waddr;
  assign mem_wdata_o         = r_wdata;
  // Hold during boot, and on every RUN write cycle.
  assign fetch_hold_o        = (r_state != ST_RUN) | r_we;
  assign fetch_flush_o       = r_first | r_hit;
  assign fetch_redirect_pc_o = r_redir;
  assign boot_done_o         = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter.
// Directed boot/corner sequences plus randomized RUN traffic vs a model.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int HW    = 8192;
  localparam int LIMIT = 8;
  localparam logic [31:0] BPC = 32'h8000_0000;

  logic        clk;
  logic        rstn;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        hold;
  logic        flush;
  logic [31:0] redir;
  logic        boot_done;

  imem_arbiter_if ld_if ();

  imem_arbiter #(
    .MEM_HWORDS  (HW),
    .BOOT_PC     (BPC),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .ld                 (ld_if),
    .fetch_pc_i         (fetch_pc),
    .fetch_stall_i      (fetch_stall),
    .mem_we_o           (mem_we),
    .mem_waddr_o        (mem_waddr),
    .mem_wdata_o        (mem_wdata),
    .fetch_hold_o       (hold),
    .fetch_flush_o      (flush),
    .fetch_redirect_pc_o(redir),
    .boot_done_o        (boot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic        last;
    logic [12:0] idx;
  } boot_vec_t;

  boot_vec_t bv[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [15:0] d, input logic l);
    ld_if.ld_valid = v;
    ld_if.ld_addr  = a;
    ld_if.ld_data  = d;
    ld_if.ld_last  = l;
  endtask

  function automatic int hidx(input logic [31:0] a);
    return int'((a >> 1) % HW);
  endfunction

  // Model of loader waiting: consecutive cycles spent valid but ungranted.
  int          since;
  logic        m_v, m_s, m_rdy, m_hs, m_hit;
  logic [31:0] m_a, m_pc, m_pc2;
  logic [15:0] m_d;
  int          sel;

  initial begin
    bv[0] = '{32'h8000_0000, 16'h0013, 1'b0, 13'd0};
    bv[1] = '{32'h8000_0002, 16'h0000, 1'b0, 13'd1};
    bv[2] = '{32'h8000_0004, 16'h0513, 1'b0, 13'd2};
    bv[3] = '{32'h8000_0006, 16'h0010, 1'b1, 13'd3};

    rstn        = 1'b0;
    fetch_pc    = 32'h8000_1000;
    fetch_stall = 1'b0;
    drive(1'b1, 32'h8000_0000, 16'hffff, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ld_if.ld_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", hold, 1);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redir, BPC);
    chk("rst_done", boot_done, 0);
    drive(1'b0, 0, 0, 1'b0);
    #3 rstn = 1'b1;

    // Reset mid-boot discards the pending write.
    tick();
    drive(1'b1, 32'h8000_0100, 16'h1234, 1'b0);
    #1 chk("mb_ready", ld_if.ld_ready, 1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("mb_we", mem_we, 1);
    rstn = 1'b0;
    #1;
    chk("mb_we_drop", mem_we, 0);
    #2 rstn = 1'b1;
    tick();
    chk("mb_hold", hold, 1);
    chk("mb_done", boot_done, 0);
    chk("mb_ready2", ld_if.ld_ready, 1);

    // Boot image load from the vector table.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bv[i].addr, bv[i].data, bv[i].last);
      #1 chk($sformatf("boot%0d_ready", i), ld_if.ld_ready, 1);
      tick();
      drive(1'b0, 0, 0, 1'b0);
      chk($sformatf("boot%0d_we", i), mem_we, 1);
      chk($sformatf("boot%0d_idx", i), mem_waddr, bv[i].idx);
      chk($sformatf("boot%0d_data", i), mem_wdata, bv[i].data);
      chk($sformatf("boot%0d_hold", i), hold, 1);
    end
    chk("drain_flush", flush, 0);
    chk("drain_done", boot_done, 0);
    ld_if.ld_valid = 1'b1;
    #1 chk("drain_ready", ld_if.ld_ready, 0);
    ld_if.ld_valid = 1'b0;
    tick();
    chk("run1_flush", flush, 1);
    chk("run1_redir", redir, BPC);
    chk("run1_done", boot_done, 1);
    chk("run1_ready", ld_if.ld_ready, 0);
    tick();
    chk("run2_flush", flush, 0);
    chk("run2_hold", hold, 0);

    // Back-to-back writes while fetch is stalled.
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0200 + 32'(2 * i), 16'(16'ha000 + i), 1'b0);
      #1 chk($sformatf("stw%0d_ready", i), ld_if.ld_ready, 1);
      tick();
      chk($sformatf("stw%0d_we", i), mem_we, 1);
      chk($sformatf("stw%0d_hold", i), hold, 1);
      chk($sformatf("stw%0d_idx", i), mem_waddr, 13'h100 + 13'(i));
    end
    drive(1'b0, 0, 0, 1'b0);
    fetch_stall = 1'b0;
    tick();
    chk("stw_end_we", mem_we, 0);
    chk("stw_end_hold", hold, 0);

    // Starvation: grants on the 9th and 18th cycle of valid.
    drive(1'b1, 32'h8000_0300, 16'h5555, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      #1 chk($sformatf("starve%0d", k), ld_if.ld_ready,
             32'((k == 9) || (k == 18)));
      tick();
    end
    drive(1'b0, 0, 0, 1'b0);
    tick();

    // Self-modify: write into the fetch window, then a control miss.
    fetch_stall = 1'b1;
    fetch_pc    = 32'h8000_0010;
    drive(1'b1, 32'h8000_0012, 16'hbeef, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("smc_we", mem_we, 1);
    chk("smc_flush", flush, 1);
    chk("smc_redir", redir, 32'h8000_0010);
    tick();
    chk("smc_flush_clr", flush, 0);
    drive(1'b1, 32'h8000_0014, 16'hcafe, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("ctl_we", mem_we, 1);
    chk("ctl_flush", flush, 0);

    // Wrap of the halfword index.
    drive(1'b1, 32'h8000_4000, 16'h7777, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk("wrap_we", mem_we, 1);
    chk("wrap_idx", mem_waddr, 0);
    fetch_stall = 1'b0;
    tick();

    // Randomized RUN traffic against the reference model.
    since = 0;
    for (int c = 0; c < 300; c++) begin
      m_v = ($urandom_range(0, 3) != 0);
      m_s = ($urandom_range(0, 3) == 0);
      m_a = $urandom;
      m_d = 16'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      m_pc = m_a;
      else if (sel == 1) m_pc = m_a - 32'd2;
      else if (sel == 2) m_pc = m_a - 32'd4;
      else               m_pc = $urandom;
      m_pc2 = m_pc + 32'd2;
      drive(m_v, m_a, m_d, 1'($urandom_range(0, 1)));
      fetch_pc    = m_pc;
      fetch_stall = m_s;
      m_rdy = m_s || (since >= LIMIT);
      m_hs  = m_v && m_rdy;
      m_hit = m_hs && ((hidx(m_a) == hidx(m_pc)) ||
                       (hidx(m_a) == hidx(m_pc2)));
      if (!m_v || m_hs) since = 0;
      else if (since < LIMIT) since++;
      #1 chk("rnd_ready", ld_if.ld_ready, 32'(m_rdy));
      tick();
      chk("rnd_we", mem_we, 32'(m_hs));
      chk("rnd_hold", hold, 32'(m_hs));
      chk("rnd_flush", flush, 32'(m_hit));
      chk("rnd_done", boot_done, 1);
      if (m_hs) begin
        chk("rnd_idx", mem_waddr, 32'(hidx(m_a)));
        chk("rnd_data", mem_wdata, 32'(m_d));
      end
      if (m_hit) chk("rnd_redir", redir, m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
